store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, address width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port memwrite  input  1  CPU store request this cycle.
REQ-006 SHALL have port dataadr  input  AW  CPU store byte address.
REQ-007 SHALL have port writedata  input  32  CPU store data.
REQ-008 SHALL have port stall  output  1  buffer cannot accept a store this cycle; CPU holds request.
REQ-009 SHALL have port mem_valid  output  1  head entry presented to data memory.
REQ-010 SHALL have port mem_addr  output  AW  head entry address.
REQ-011 SHALL have port mem_wdata  output  32  head entry data.
REQ-012 SHALL have port mem_ready  input  1  data memory accepts head entry this cycle.
REQ-013 SHALL have port empty  output  1  no entries pending.
REQ-014 SHALL have port misalign  output  1  sticky flag, a store with dataadr[1:0] != 0 was seen.
REQ-015 SHALL have port ldaddr  input  AW  CPU load address for forwarding lookup.
REQ-016 SHALL have port fwd_hit  output  1  ldaddr matches a pending entry.
REQ-017 SHALL have port fwd_data  output  32  data of youngest matching entry.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH and an occupancy count 0..DEPTH.
REQ-019 SHALL assert stall combinationally when memwrite=1 and count=DEPTH; no push occurs that cycle.
REQ-020 SHALL push {dataadr, writedata} at the tail on a rising edge when memwrite=1 and stall=0.
REQ-021 SHALL drive mem_valid = (count != 0); mem_addr/mem_wdata = head entry when valid, 0 when empty.
REQ-022 SHALL pop the head on a rising edge when mem_valid=1 and mem_ready=1.
REQ-023 SHALL hold mem_valid, mem_addr, mem_wdata stable while mem_valid=1 and mem_ready=0.
REQ-024 SHALL have latency of exactly one cycle: a store pushed at edge N is visible on mem_valid after edge N when buffer was empty; no combinational pass-through.
REQ-025 SHALL, on simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
REQ-026 SHALL, when full, stall a new store even if a pop occurs that same cycle (stall depends on count only).
REQ-027 SHALL preserve store order: memory sees entries in exact push order.
REQ-028 SHALL set misalign on any accepted store with dataadr[1:0] != 0; the store is still buffered unchanged; flag clears only on reset.
REQ-029 SHALL drive empty = (count == 0).
REQ-030 SHALL ignore mem_ready when mem_valid=0.

Reset
REQ-031 SHALL, with reset=1 at a rising edge, clear pointers, count and misalign, discarding pending entries (including mid-drain); memwrite/mem_ready ignored that cycle.
REQ-032 SHALL present after reset: stall=0, mem_valid=0, mem_addr=0, mem_wdata=0, empty=1, misalign=0, fwd_hit=0, fwd_data=0.

Configuration
REQ-033 SHALL, with macro STORE_BUFFER_FORWARD_EN defined, compare ldaddr against all valid entries combinationally and drive fwd_hit=1 and fwd_data=youngest matching entry; an entry popping this cycle still counts as valid.
REQ-034 SHALL, with STORE_BUFFER_FORWARD_EN undefined, keep all ports, ignore ldaddr, and tie fwd_hit=0, fwd_data=0.

Verification
REQ-035 Single store: memwrite=1, dataadr=84, writedata=7, mem_ready=1 -> next cycle mem_valid=1, mem_addr=84, mem_wdata=7; one cycle later empty=1.
REQ-036 Fill: mem_ready=0, stores to 80,84,88,92,96 -> first four accepted, fifth sees stall=1; raise mem_ready -> drained as 80,84,88,92, then 96 accepted and drained last.
REQ-037 Backpressure: one entry, mem_ready=0 for 5 cycles -> mem_addr/mem_wdata constant, count unchanged.
REQ-038 Simultaneous push/pop at count=2 -> count stays 2, order preserved.
REQ-039 Forwarding (macro on): stores 84<-7 then 84<-9 pending, ldaddr=84 -> fwd_hit=1, fwd_data=9; ldaddr=88 -> fwd_hit=0; macro off -> fwd_hit=0.
REQ-040 Misalign/reset: store to 0x55 -> misalign=1; reset asserted with 3 pending -> after edge empty=1, mem_valid=0, misalign=0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending CPU stores draining to data memory.
// Define STORE_BUFFER_FORWARD_EN to enable load-address forwarding from pending entries.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [31:0]   writedata,
    output logic          stall,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          empty,
    output logic          misalign,
    input  logic [AW-1:0] ldaddr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [PW:0]   r_count;
    logic          r_misalign;
    logic          w_push, w_pop;
    // Full stalls regardless of a same-cycle pop, so stall depends on count only.
    assign stall     = memwrite && (r_count == (PW+1)'(DEPTH));
    assign mem_valid = r_count != '0;
    assign empty     = r_count == '0;
    assign mem_addr  = mem_valid ? r_addr[r_head] : '0;
    assign mem_wdata = mem_valid ? r_data[r_head] : '0;
    assign misalign  = r_misalign;
    assign w_push    = memwrite && !stall;
    assign w_pop     = mem_valid && mem_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= dataadr;
                r_data[r_tail] <= writedata;
                r_tail         <= r_tail + 1'b1;
                if (dataadr[1:0] != 2'b00) r_misalign <= 1'b1;
            end
            if (w_pop) r_head <= r_head + 1'b1;
            if (w_push && !w_pop) r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end
`ifdef STORE_BUFFER_FORWARD_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (((PW+1)'(k) < r_count) && (r_addr[w_idx] == ldaddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_idx];
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^ldaddr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset, memwrite, mem_ready;
    logic [31:0] dataadr, writedata, ldaddr;
    logic        stall, mem_valid, empty, misalign, fwd_hit;
    logic [31:0] mem_addr, mem_wdata, fwd_data;
    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .empty(empty), .misalign(misalign), .ldaddr(ldaddr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; mem_ready = 1'b0;
        dataadr = '0; writedata = '0; ldaddr = '0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_stall", stall, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_empty", empty, 1);
        chk("rst_misalign", misalign, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);

        // single store, one-cycle latency, no pass-through
        mem_ready = 1'b1; store(84, 7); #1;
        chk("single_nopass", mem_valid, 0);
        chk("single_stall", stall, 0);
        tick(); memwrite = 1'b0; #1;
        chk("single_valid", mem_valid, 1);
        chk("single_addr", mem_addr, 84);
        chk("single_wdata", mem_wdata, 7);
        tick(); #1;
        chk("single_empty", empty, 1);
        chk("single_valid0", mem_valid, 0);
        chk("single_addr0", mem_addr, 0);

        // fill, stall when full even with a same-cycle pop, then drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(80 + 4 * i, i + 1); #1;
            chk("fill_stall0", stall, 0);
            tick();
        end
        store(96, 5); #1;
        chk("full_stall", stall, 1);
        chk("full_head", mem_addr, 80);
        tick(); #1;
        chk("full_stall2", stall, 1);
        mem_ready = 1'b1; #1;
        chk("full_pop_stall", stall, 1);
        chk("drain0_addr", mem_addr, 80);
        chk("drain0_data", mem_wdata, 1);
        tick(); #1;
        chk("after_pop_stall", stall, 0);
        chk("drain1_addr", mem_addr, 84);
        tick(); memwrite = 1'b0; #1;
        chk("drain2_addr", mem_addr, 88);
        chk("drain2_data", mem_wdata, 3);
        tick(); #1;
        chk("drain3_addr", mem_addr, 92);
        tick(); #1;
        chk("drain4_addr", mem_addr, 96);
        chk("drain4_data", mem_wdata, 5);
        tick(); #1;
        chk("drain_empty", empty, 1);

        // backpressure holds head stable
        mem_ready = 1'b0; store(100, 32'hAB);
        tick(); memwrite = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", mem_valid, 1);
            chk("bp_addr", mem_addr, 100);
            chk("bp_wdata", mem_wdata, 32'hAB);
            tick(); #1;
        end
        mem_ready = 1'b1;
        tick(); #1;
        chk("bp_empty", empty, 1);

        // simultaneous push/pop at count 2
        mem_ready = 1'b0; store(200, 1); tick();
        store(204, 2); tick();
        store(208, 3); mem_ready = 1'b1; tick();
        memwrite = 1'b0; #1;
        chk("pp_addr1", mem_addr, 204);
        chk("pp_data1", mem_wdata, 2);
        tick(); #1;
        chk("pp_addr2", mem_addr, 208);
        chk("pp_data2", mem_wdata, 3);
        tick(); #1;
        chk("pp_empty", empty, 1);

        // forwarding lookup
        mem_ready = 1'b0; store(84, 7); tick();
        store(84, 9); tick();
        memwrite = 1'b0; ldaddr = 84; #1;
`ifdef STORE_BUFFER_FORWARD_EN
        chk("fwd84_hit", fwd_hit, 1);
        chk("fwd84_data", fwd_data, 9);
`else
        chk("fwd84_hit", fwd_hit, 0);
        chk("fwd84_data", fwd_data, 0);
`endif
        ldaddr = 88; #1;
        chk("fwd88_hit", fwd_hit, 0);
        chk("fwd88_data", fwd_data, 0);

        // misaligned store is flagged, then reset discards 3 pending entries
        chk("pre_misalign", misalign, 0);
        store(32'h55, 32'h11); tick();
        memwrite = 1'b0; #1;
        chk("misalign_set", misalign, 1);
        chk("misalign_head", mem_addr, 84);
        reset = 1'b1; memwrite = 1'b1; mem_ready = 1'b1;
        tick();
        reset = 1'b0; memwrite = 1'b0; mem_ready = 1'b0; #1;
        chk("rst2_empty", empty, 1);
        chk("rst2_valid", mem_valid, 0);
        chk("rst2_misalign", misalign, 0);
        chk("rst2_addr", mem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
